// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Digit and overflow outputs are registered and only change on the done edge.
module bin2bcd_seq #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] bin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         ovf_o,
  output logic [3:0]   bcd3_o,
  output logic [3:0]   bcd2_o,
  output logic [3:0]   bcd1_o,
  output logic [3:0]   bcd0_o
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e         r_state;
  logic [W-1:0]   r_bin;
  logic [15:0]    r_scr;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf_pend;
  logic           r_busy;
  logic           r_done;
  logic           r_ovf;
  logic [3:0]     r_bcd3;
  logic [3:0]     r_bcd2;
  logic [3:0]     r_bcd1;
  logic [3:0]     r_bcd0;

  logic [15:0]    w_adj;
  logic [15:0]    w_scr_next;
  logic           w_last;

  // Add-3 per nibble is confined to the nibble; no carry into the next digit.
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < 4; i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_scr_next = {w_adj[14:0], r_bin[W-1]};
  assign w_last     = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_bin      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_bcd3     <= '0;
      r_bcd2     <= '0;
      r_bcd1     <= '0;
      r_bcd0     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_state    <= StShift;
            r_bin      <= bin_i;
            r_scr      <= '0;
            r_cnt      <= CW'(W);
            r_ovf_pend <= (32'(bin_i) > 32'd9999);
            r_busy     <= 1'b1;
          end
        end
        StShift: begin
          r_scr <= w_scr_next;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ovf   <= r_ovf_pend;
            // Saturate so the display shows 9999 rather than wrapped digits.
            if (r_ovf_pend) begin
              r_bcd3 <= 4'd9;
              r_bcd2 <= 4'd9;
              r_bcd1 <= 4'd9;
              r_bcd0 <= 4'd9;
            end else begin
              r_bcd3 <= w_scr_next[15:12];
              r_bcd2 <= w_scr_next[11:8];
              r_bcd1 <= w_scr_next[7:4];
              r_bcd0 <= w_scr_next[3:0];
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign ovf_o  = r_ovf;
  assign bcd3_o = r_bcd3;
  assign bcd2_o = r_bcd2;
  assign bcd1_o = r_bcd1;
  assign bcd0_o = r_bcd0;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes decimal-arithmetic expectations,
// a negedge monitor pops and compares on every done_o and checks outputs hold otherwise.
module tb_bin2bcd_seq;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] bin_i = '0;
  logic         busy_o;
  logic         done_o;
  logic         ovf_o;
  logic [3:0]   bcd3_o;
  logic [3:0]   bcd2_o;
  logic [3:0]   bcd1_o;
  logic [3:0]   bcd0_o;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       ovf;
  } res_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  res_t exp_q[$];
  int   done_cyc[$];
  res_t last = '0;

  bin2bcd_seq #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .ovf_o   (ovf_o),
    .bcd3_o  (bcd3_o),
    .bcd2_o  (bcd2_o),
    .bcd1_o  (bcd1_o),
    .bcd0_o  (bcd0_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain decimal arithmetic with saturation at 9999.
  function automatic res_t model(input int v);
    res_t r;
    int   s;
    s     = (v > 9999) ? 9999 : v;
    r.d3  = 4'((s / 1000) % 10);
    r.d2  = 4'((s / 100) % 10);
    r.d1  = 4'((s / 10) % 10);
    r.d0  = 4'(s % 10);
    r.ovf = (v > 9999);
    return r;
  endfunction

  // Monitor: compare on done_o, otherwise outputs must hold their last value.
  always @(negedge clk) begin
    res_t e;
    res_t cur;
    cur = {bcd3_o, bcd2_o, bcd1_o, bcd0_o, ovf_o};
    if (!rst) begin
      last = '0;
    end else if (done_o) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("bcd3", 32'(bcd3_o), 32'(e.d3));
        check("bcd2", 32'(bcd2_o), 32'(e.d2));
        check("bcd1", 32'(bcd1_o), 32'(e.d1));
        check("bcd0", 32'(bcd0_o), 32'(e.d0));
        check("ovf", 32'(ovf_o), 32'(e.ovf));
        check("busy_at_done", 32'(busy_o), 32'd0);
      end
      check("digit_range",
            32'((bcd3_o <= 4'd9) && (bcd2_o <= 4'd9) && (bcd1_o <= 4'd9) && (bcd0_o <= 4'd9)),
            32'd1);
      last = cur;
    end else begin
      check("hold", 32'(cur), 32'(last));
    end
  end

  task automatic convert(input int v);
    int g;
    g = 0;
    @(negedge clk);
    while (busy_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("busy_timeout", 32'd1, 32'd0);
    bin_i   = W'(v);
    start_i = 1'b1;
    exp_q.push_back(model(v));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start_i = 1'b0;
    bin_i   = W'($urandom);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy_o) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int nd;
    int bounds[13] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16382, 16383};

    // Reset state
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_out", 32'({bcd3_o, bcd2_o, bcd1_o, bcd0_o, ovf_o}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1234: busy width and latency
    convert(1234);
    nb = 0;
    @(negedge clk);
    while (busy_o && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(nb), 32'd14);
    wait_done();
    check("latency", 32'(done_cyc[$] - acc_cyc), 32'd14);

    // Back-to-back with start held high: 0 then 9999
    @(negedge clk);
    bin_i   = W'(0);
    start_i = 1'b1;
    exp_q.push_back(model(0));
    exp_q.push_back(model(9999));
    @(posedge clk);
    #1;
    bin_i = W'(9999);
    repeat (15) @(posedge clk);
    #1;
    check("second_accept_busy", 32'(busy_o), 32'd1);
    start_i = 1'b0;
    wait_done();
    check("b2b_spacing", 32'(done_cyc[$] - done_cyc[$-1]), 32'd15);

    // Overflow saturation, then clearing
    convert(10000);
    wait_done();
    convert(16383);
    wait_done();
    convert(42);
    wait_done();

    // Start while busy is ignored
    convert(1234);
    wait_done();
    nd = done_cyc.size();
    convert(5678);
    repeat (4) @(negedge clk);
    bin_i   = W'(1111);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    check("one_done", 32'(done_cyc.size() - nd), 32'd1);

    // Asynchronous reset mid-conversion
    convert(8888);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out", 32'({bcd3_o, bcd2_o, bcd1_o, bcd0_o, ovf_o}), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_done", 32'(done_o), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    nd = done_cyc.size();
    repeat (20) @(negedge clk);
    check("no_done_after_rst", 32'(done_cyc.size() - nd), 32'd0);
    convert(8888);
    wait_done();

    // Boundaries plus random sample across the full input range
    foreach (bounds[i]) convert(bounds[i]);
    for (int i = 0; i < 2500; i++) convert(int'($urandom_range(0, 16383)));
    wait_done();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
